// File: rtl/fixed_divider_seq.sv
// Signed fixed-point sequential divider, Q(WIDTH-FRAC_BITS).FRAC_BITS.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, followed by sign application and saturation. Operands arrive on two
// independent ready/valid channels; the result leaves on a third.
module fixed_divider_seq #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             dividend_s_ready,
    input  logic             dividend_s_valid,
    input  logic [WIDTH-1:0] dividend_s_data,
    output logic             divisor_s_ready,
    input  logic             divisor_s_valid,
    input  logic [WIDTH-1:0] divisor_s_data,
    input  logic             result_m_ready,
    output logic             result_m_valid,
    output logic [WIDTH-1:0] result_m_data,
    output logic [1:0]       result_m_status
);

    localparam int ITERS   = WIDTH + FRAC_BITS;
    localparam int LATENCY = WIDTH + FRAC_BITS + 2;
    // Counter only needs to hold ITERS-1; sizing from LATENCY keeps headroom.
    localparam int CNT_W   = $clog2(LATENCY);

    // Saturation limits on the full quotient width and on the result width.
    localparam logic [ITERS-1:0] NEG_LIMIT = ITERS'(1) << (WIDTH - 1);
    localparam logic [ITERS-1:0] POS_LIMIT = NEG_LIMIT - ITERS'(1);
    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg, state_next;

    logic               dividend_held_reg, dividend_held_next;
    logic               divisor_held_reg, divisor_held_next;
    logic [WIDTH-1:0]   dividend_data_reg, dividend_data_next;
    logic [WIDTH-1:0]   divisor_data_reg, divisor_data_next;

    // Quotient register starts holding the scaled dividend magnitude; its
    // top bit is shifted into the remainder on every step.
    logic [ITERS-1:0]   quo_reg, quo_next;
    logic [WIDTH-1:0]   rem_reg, rem_next;
    logic [WIDTH-1:0]   dsr_reg, dsr_next;
    logic               sign_reg, sign_next;
    logic               dz_reg, dz_next;
    logic               dneg_reg, dneg_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;

    logic [WIDTH-1:0]   result_data_reg, result_data_next;
    logic [1:0]         result_status_reg, result_status_next;
    logic               result_valid_reg, result_valid_next;

    logic               dividend_fire, divisor_fire, join_now;
    logic [WIDTH-1:0]   dividend_eff, divisor_eff;
    logic [WIDTH-1:0]   dividend_mag, divisor_mag;
    logic [ITERS-1:0]   dividend_load;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               step_ge;
    logic [WIDTH-1:0]   quo_low;

    // Magnitude of a two's complement value; the most negative value maps to
    // 2^(WIDTH-1), which is exact as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    // Readies depend only on state and held flags, never on the valids.
    assign dividend_s_ready = (state_reg == IDLE) && !dividend_held_reg;
    assign divisor_s_ready  = (state_reg == IDLE) && !divisor_held_reg;
    assign dividend_fire    = dividend_s_valid && dividend_s_ready;
    assign divisor_fire     = divisor_s_valid && divisor_s_ready;

    // An operand arriving on the join edge is used directly from the port.
    assign dividend_eff = dividend_fire ? dividend_s_data : dividend_data_reg;
    assign divisor_eff  = divisor_fire  ? divisor_s_data  : divisor_data_reg;
    assign join_now     = (state_reg == IDLE)
                          && (dividend_held_reg || dividend_fire)
                          && (divisor_held_reg  || divisor_fire);

    assign dividend_mag = magnitude(dividend_eff);
    assign divisor_mag  = magnitude(divisor_eff);

    // Scale the dividend magnitude by 2^FRAC_BITS so the integer quotient
    // carries FRAC_BITS fractional bits.
    genvar gi;
    generate
        for (gi = 0; gi < ITERS; gi++) begin : g_load
            if (gi < FRAC_BITS) begin : g_frac
                assign dividend_load[gi] = 1'b0;
            end else begin : g_int
                assign dividend_load[gi] = dividend_mag[gi-FRAC_BITS];
            end
        end
    endgenerate

    // Restoring step. The remainder stays below the divisor, so the
    // difference always fits in WIDTH bits whenever it is kept.
    assign rem_shift = {rem_reg, quo_reg[ITERS-1]};
    assign step_ge   = rem_shift >= {1'b0, dsr_reg};
    assign rem_diff  = rem_shift[WIDTH-1:0] - dsr_reg;
    assign quo_low   = quo_reg[WIDTH-1:0];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            dividend_held_reg <= 1'b0;
            divisor_held_reg  <= 1'b0;
            dividend_data_reg <= '0;
            divisor_data_reg  <= '0;
            quo_reg           <= '0;
            rem_reg           <= '0;
            dsr_reg           <= '0;
            sign_reg          <= 1'b0;
            dz_reg            <= 1'b0;
            dneg_reg          <= 1'b0;
            cnt_reg           <= '0;
            result_data_reg   <= '0;
            result_status_reg <= '0;
            result_valid_reg  <= 1'b0;
        end else begin
            state_reg         <= state_next;
            dividend_held_reg <= dividend_held_next;
            divisor_held_reg  <= divisor_held_next;
            dividend_data_reg <= dividend_data_next;
            divisor_data_reg  <= divisor_data_next;
            quo_reg           <= quo_next;
            rem_reg           <= rem_next;
            dsr_reg           <= dsr_next;
            sign_reg          <= sign_next;
            dz_reg            <= dz_next;
            dneg_reg          <= dneg_next;
            cnt_reg           <= cnt_next;
            result_data_reg   <= result_data_next;
            result_status_reg <= result_status_next;
            result_valid_reg  <= result_valid_next;
        end
    end

    // Next-state and datapath updates for each FSM state.
    always_comb begin
        state_next         = state_reg;
        dividend_held_next = dividend_held_reg;
        divisor_held_next  = divisor_held_reg;
        dividend_data_next = dividend_data_reg;
        divisor_data_next  = divisor_data_reg;
        quo_next           = quo_reg;
        rem_next           = rem_reg;
        dsr_next           = dsr_reg;
        sign_next          = sign_reg;
        dz_next            = dz_reg;
        dneg_next          = dneg_reg;
        cnt_next           = cnt_reg;
        result_data_next   = result_data_reg;
        result_status_next = result_status_reg;
        result_valid_next  = result_valid_reg;

        case (state_reg)
            IDLE: begin
                if (dividend_fire) begin
                    dividend_held_next = 1'b1;
                    dividend_data_next = dividend_s_data;
                end
                if (divisor_fire) begin
                    divisor_held_next = 1'b1;
                    divisor_data_next = divisor_s_data;
                end
                if (join_now) begin
                    state_next         = CALC;
                    dividend_held_next = 1'b0;
                    divisor_held_next  = 1'b0;
                    quo_next           = dividend_load;
                    rem_next           = '0;
                    dsr_next           = divisor_mag;
                    sign_next          = dividend_eff[WIDTH-1] ^ divisor_eff[WIDTH-1];
                    dz_next            = (divisor_eff == '0);
                    dneg_next          = dividend_eff[WIDTH-1];
                    cnt_next           = CNT_W'(ITERS - 1);
                end
            end

            CALC: begin
                // A zero divisor still iterates so latency does not depend on data.
                quo_next = {quo_reg[ITERS-2:0], step_ge};
                rem_next = step_ge ? rem_diff : rem_shift[WIDTH-1:0];
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == '0) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                if (dz_reg) begin
                    result_data_next   = dneg_reg ? MIN_NEG : MAX_POS;
                    result_status_next = 2'b01;
                end else if (!sign_reg) begin
                    if (quo_reg > POS_LIMIT) begin
                        result_data_next   = MAX_POS;
                        result_status_next = 2'b10;
                    end else begin
                        result_data_next   = quo_low;
                        result_status_next = 2'b00;
                    end
                end else begin
                    if (quo_reg > NEG_LIMIT) begin
                        result_data_next   = MIN_NEG;
                        result_status_next = 2'b10;
                    end else begin
                        result_data_next   = WIDTH'(0) - quo_low;
                        result_status_next = 2'b00;
                    end
                end
                state_next = DONE;
            end

            DONE: begin
                // First DONE cycle raises valid from a register; then hold
                // until the downstream handshake.
                if (!result_valid_reg) begin
                    result_valid_next = 1'b1;
                end else if (result_m_ready) begin
                    result_valid_next = 1'b0;
                    state_next        = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result_m_valid  = result_valid_reg;
    assign result_m_data   = result_data_reg;
    assign result_m_status = result_status_reg;

endmodule
